// File: rtl/exprom_ctrl.sv
// PCI expansion-ROM target controller: Expansion ROM BAR, request decode, and a
// single-slot read response built on the ROM's own registered output.
module exprom_ctrl #(
    parameter int ROM_AW        = 9,
    parameter int BAR_SIZE_LOG2 = 11,
    parameter int WRITABLE      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_en_i,
    input  logic              cfg_we_i,
    input  logic [3:0]        cfg_be_i,
    input  logic [31:0]       cfg_wdata_i,
    output logic [31:0]       cfg_bar_o,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [31:0]       req_addr_i,
    input  logic [3:0]        req_be_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_hit_o,
    output logic [31:0]       rsp_data_o,
    output logic              wr_drop_o,
    output logic [ROM_AW-1:0] rom_address_o,
    output logic              rom_enable_o,
    output logic              rom_wren_o,
    output logic [31:0]       rom_dinp_o,
    input  logic [31:0]       rom_dout_i
);

    localparam logic [31:0] BAR_MASK = ({32{1'b1}} << BAR_SIZE_LOG2) | 32'h1;
    localparam logic        WR_EN    = (WRITABLE != 0);

    logic [31:0] bar_q, bar_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        hit_q, hit_d;
    logic        wr_drop_q, wr_drop_d;

    logic hit, accept, full_wr, commit_wr;
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^req_addr_i[1:0];

    // Decode always uses the BAR as it stood before this cycle's cfg write.
    assign hit = mem_en_i & bar_q[0]
               & (req_addr_i[31:BAR_SIZE_LOG2] == bar_q[31:BAR_SIZE_LOG2]);

    assign req_ready_o = !rsp_valid_q | rsp_ready_i;
    assign accept      = req_valid_i & req_ready_o;
    assign full_wr     = req_write_i & (req_be_i == 4'hF);
    assign commit_wr   = accept & hit & full_wr & WR_EN;

    assign rom_address_o = req_addr_i[ROM_AW+1:2];
    assign rom_dinp_o    = req_wdata_i;
    // The ROM only clocks when a new read is taken or a write commits, so a
    // stalled response keeps its data on the ROM output register.
    assign rom_enable_o  = (accept & hit & !req_write_i) | commit_wr;
    assign rom_wren_o    = commit_wr;

    always_comb begin
        bar_d = bar_q;
        if (cfg_we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (cfg_be_i[b]) bar_d[8*b +: 8] = cfg_wdata_i[8*b +: 8];
            end
        end
        bar_d = bar_d & BAR_MASK;
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        hit_d       = hit_q;
        if (accept && !req_write_i) begin
            rsp_valid_d = 1'b1;
            hit_d       = hit;
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
        wr_drop_d = accept & req_write_i & hit & !(full_wr & WR_EN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_q       <= '0;
            rsp_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            wr_drop_q   <= 1'b0;
        end else begin
            bar_q       <= bar_d;
            rsp_valid_q <= rsp_valid_d;
            hit_q       <= hit_d;
            wr_drop_q   <= wr_drop_d;
        end
    end

    assign cfg_bar_o   = bar_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_hit_o   = hit_q;
    assign rsp_data_o  = hit_q ? rom_dout_i : '0;
    assign wr_drop_o   = wr_drop_q;

endmodule
